// File: rtl/data_ram_banked_pkg.sv
// Shared constants and types for the banked data RAM.
// Replaces the old defines file: chip/write enable levels, bus widths,
// the zero word and the MARS data-segment base address.
package data_ram_banked_pkg;

   localparam logic        ChipEnable   = 1'b1;
   localparam logic        ChipDisable  = 1'b0;
   localparam logic        WriteEnable  = 1'b1;
   localparam logic        WriteDisable = 1'b0;
   localparam int          DataBus      = 32;
   localparam int          ByteWidth    = 8;
   localparam logic [31:0] ZeroWord     = 32'h0000_0000;
   localparam logic [31:0] DataRamBase  = 32'h1001_0000;

   // CLEAR sweeps zeros through every word; IDLE serves accesses.
   typedef enum logic {
      StClear = 1'b0,
      StIdle  = 1'b1
   } ramState_e;

endpackage

// File: rtl/data_ram_banked_if.sv
// Load/store bus between the MEM stage (master) and the data RAM (slave).
interface data_ram_banked_if;
   import data_ram_banked_pkg::*;

   logic               ce;
   logic               we;
   logic [31:0]        addr;
   logic [3:0]         sel;
   logic [DataBus-1:0] data_i;
   logic               clear_req;
   logic               ready;
   logic               rvalid;
   logic [DataBus-1:0] data_o;
   logic               err;

   modport master (
      output ce, we, addr, sel, data_i, clear_req,
      input  ready, rvalid, data_o, err
   );

   modport slave (
      input  ce, we, addr, sel, data_i, clear_req,
      output ready, rvalid, data_o, err
   );

endinterface

// File: rtl/data_ram_banked_lane.sv
// One byte lane of the data RAM: DEPTH x 8 single-port array with a
// registered read port. With DATA_RAM_SEG_TAP_EN defined the lane also
// exposes the byte at TAP_INDEX combinationally for the display tap.
module data_ram_lane
   import data_ram_banked_pkg::*;
#(
   parameter int DEPTH = 1024,
   parameter int IDX_W = $clog2(DEPTH)
`ifdef DATA_RAM_SEG_TAP_EN
   ,
   parameter int TAP_INDEX = 0
`endif
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_we,
   input  logic                 i_re,
   input  logic [IDX_W-1:0]     i_idx,
   input  logic [ByteWidth-1:0] i_wdata,
   output logic [ByteWidth-1:0] o_rdata
`ifdef DATA_RAM_SEG_TAP_EN
   ,
   output logic [ByteWidth-1:0] o_tap
`endif
);

   logic [ByteWidth-1:0] r_mem [DEPTH];
   logic [ByteWidth-1:0] r_rdata;

   // Storage write: contents have no reset, the top-level sweep clears them.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_idx] <= i_wdata;
      end
   end

   // Registered read data, only updated by an accepted in-window read so it holds between responses.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rdata <= '0;
      end else if (i_re) begin
         r_rdata <= r_mem[i_idx];
      end
   end

   assign o_rdata = r_rdata;

`ifdef DATA_RAM_SEG_TAP_EN
   localparam logic [IDX_W-1:0] TapIdx = TAP_INDEX[IDX_W-1:0];
   assign o_tap = r_mem[TapIdx];
`endif

endmodule

// File: rtl/data_ram_banked.sv
// Banked MEM-stage data RAM: four byte lanes behind a windowed address
// decoder, 1-cycle registered reads with rvalid, out-of-window err pulse,
// and a zero-fill sweep after reset or on clear_req (ready low meanwhile).
// Optional display tap on seg7x16_data when DATA_RAM_SEG_TAP_EN is defined.
module data_ram_banked
   import data_ram_banked_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = DataRamBase,
   parameter int          DEPTH     = 1024,
   parameter int          IDX_W     = $clog2(DEPTH),
   parameter int          TAP_INDEX = 0
) (
   input  logic               clk,
   input  logic               rst,
   data_ram_banked_if.slave   bus
`ifdef DATA_RAM_SEG_TAP_EN
   ,
   output logic [DataBus-1:0] seg7x16_data
`endif
);

   ramState_e          r_state;
   ramState_e          w_nextState;
   logic [IDX_W-1:0]   r_clrPtr;
   logic               r_rvalid;
   logic               r_err;
   logic               r_oobRead;

   logic [31:0]        w_off;
   logic               w_inWindow;
   logic [IDX_W-1:0]   w_index;
   logic [IDX_W-1:0]   w_laneIdx;
   logic               w_clearing;
   logic               w_accept;
   logic               w_isRead;
   logic               w_readHit;
   logic               w_writeHit;
   logic [3:0]         w_laneWe;
   logic [DataBus-1:0] w_laneWdata;
   logic [DataBus-1:0] w_laneQ;
   logic               w_unusedBits;

   // Addresses below the base wrap to huge offsets and fall out of the window.
   assign w_off        = bus.addr - BASE_ADDR;
   assign w_inWindow   = (w_off[31:IDX_W+2] == '0);
   assign w_index      = w_off[IDX_W+1:2];
   assign w_unusedBits = &{1'b0, w_off[1:0]};

   assign w_clearing = (r_state == StClear);
   assign bus.ready  = (r_state == StIdle);
   assign w_accept   = (bus.ce == ChipEnable) && bus.ready;
   assign w_isRead   = (bus.we == WriteDisable);
   assign w_readHit  = w_accept && w_isRead && w_inWindow;
   assign w_writeHit = w_accept && (bus.we == WriteEnable) && w_inWindow;

   // State and sweep pointer; the pointer parks at 0 in IDLE so every sweep starts at word 0.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= StClear;
         r_clrPtr <= '0;
      end else begin
         r_state <= w_nextState;
         if (w_clearing) begin
            r_clrPtr <= r_clrPtr + 1'b1;
         end else begin
            r_clrPtr <= '0;
         end
      end
   end

   // Next state: leave CLEAR after the last word; clear_req in IDLE starts a sweep after any same-cycle access.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         StClear: begin
            if (r_clrPtr == IDX_W'(DEPTH - 1)) begin
               w_nextState = StIdle;
            end
         end
         StIdle: begin
            if (bus.clear_req) begin
               w_nextState = StClear;
            end
         end
         default: w_nextState = StClear;
      endcase
   end

   // Response strobes; r_oobRead forces zero data for an out-of-window read and holds until the next read.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rvalid  <= 1'b0;
         r_err     <= 1'b0;
         r_oobRead <= 1'b0;
      end else begin
         r_rvalid <= w_accept && w_isRead;
         r_err    <= w_accept && !w_inWindow;
         if (w_accept && w_isRead) begin
            r_oobRead <= !w_inWindow;
         end
      end
   end

   assign w_laneIdx   = w_clearing ? r_clrPtr : w_index;
   assign w_laneWdata = w_clearing ? ZeroWord : bus.data_i;

   for (genvar k = 0; k < 4; k++) begin : g_lane
      assign w_laneWe[k] = w_clearing || (w_writeHit && bus.sel[k]);

      data_ram_lane #(
         .DEPTH     (DEPTH),
         .IDX_W     (IDX_W)
`ifdef DATA_RAM_SEG_TAP_EN
         ,
         .TAP_INDEX (TAP_INDEX)
`endif
      ) u_lane (
         .clk     (clk),
         .rst     (rst),
         .i_we    (w_laneWe[k]),
         .i_re    (w_readHit),
         .i_idx   (w_laneIdx),
         .i_wdata (w_laneWdata[ByteWidth*k +: ByteWidth]),
         .o_rdata (w_laneQ[ByteWidth*k +: ByteWidth])
`ifdef DATA_RAM_SEG_TAP_EN
         ,
         .o_tap   (seg7x16_data[ByteWidth*k +: ByteWidth])
`endif
      );
   end

   assign bus.rvalid = r_rvalid;
   assign bus.err    = r_err;
   assign bus.data_o = r_oobRead ? ZeroWord : w_laneQ;

`ifndef DATA_RAM_SEG_TAP_EN
   logic w_unusedTap;
   assign w_unusedTap = TAP_INDEX[0];
`endif

endmodule

// File: tb/tb_data_ram_banked.sv
// Directed self-checking bench for data_ram_banked (default DEPTH=1024).
module tb_data_ram_banked;
   import data_ram_banked_pkg::*;

   localparam int          DEPTH = 1024;
   localparam logic [31:0] BASE  = 32'h1001_0000;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   testsRun = 0;
   int   testsFailed = 0;
   int   stallCycles;

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   data_ram_banked_if bus ();

`ifdef DATA_RAM_SEG_TAP_EN
   logic [31:0] seg;
`endif

   data_ram_banked #(
      .BASE_ADDR (BASE),
      .DEPTH     (DEPTH),
      .TAP_INDEX (0)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus.slave)
`ifdef DATA_RAM_SEG_TAP_EN
      ,
      .seg7x16_data (seg)
`endif
   );

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Drive one bus request; held until changed.
   task automatic applyStimulus(input logic ce, input logic we, input logic [31:0] addr,
                                input logic [3:0] sel, input logic [31:0] data, input logic clr);
      bus.ce        = ce;
      bus.we        = we;
      bus.addr      = addr;
      bus.sel       = sel;
      bus.data_i    = data;
      bus.clear_req = clr;
   endtask

   // Advance one clock and settle just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Count cycles with ready low, bounded so a stuck sweep still ends.
   task automatic countStall(output int n);
      n = 0;
      while (!bus.ready && n < DEPTH + 16) begin
         tick();
         n++;
      end
   endtask

   // Directed sequence following the test plan.
   initial begin
      applyStimulus(ChipEnable, WriteDisable, BASE, 4'hF, 32'h0, 1'b0);
      tick();
      tick();
      checkOutput("rstReady",  {31'b0, bus.ready},  32'h0);
      checkOutput("rstRvalid", {31'b0, bus.rvalid}, 32'h0);
      checkOutput("rstErr",    {31'b0, bus.err},    32'h0);
      checkOutput("rstData",   bus.data_o,          32'h0);

      rst = 1'b1;
      countStall(stallCycles);
      checkOutput("sweepStall", stallCycles, DEPTH);
      tick();
      checkOutput("firstRvalid", {31'b0, bus.rvalid}, 32'h1);
      checkOutput("firstData",   bus.data_o,          32'h0);
      checkOutput("firstErr",    {31'b0, bus.err},    32'h0);

      applyStimulus(ChipEnable, WriteEnable, BASE + 32'h4, 4'hF, 32'hDEAD_BEEF, 1'b0);
      tick();
      checkOutput("wrRvalid", {31'b0, bus.rvalid}, 32'h0);
      checkOutput("wrErr",    {31'b0, bus.err},    32'h0);
      applyStimulus(ChipEnable, WriteDisable, BASE + 32'h4, 4'hF, 32'h0, 1'b0);
      tick();
      checkOutput("rdRvalid", {31'b0, bus.rvalid}, 32'h1);
      checkOutput("rdData",   bus.data_o,          32'hDEAD_BEEF);
      checkOutput("rdErr",    {31'b0, bus.err},    32'h0);

      applyStimulus(ChipEnable, WriteEnable, BASE + 32'h4, 4'b0100, 32'h0011_2233, 1'b0);
      tick();
      applyStimulus(ChipEnable, WriteDisable, BASE + 32'h4, 4'h0, 32'h0, 1'b0);
      tick();
      checkOutput("laneData", bus.data_o, 32'hDE11_BEEF);
      applyStimulus(ChipDisable, WriteDisable, BASE, 4'h0, 32'h0, 1'b0);
      tick();
      checkOutput("idleRvalid", {31'b0, bus.rvalid}, 32'h0);
      checkOutput("holdData",   bus.data_o,          32'hDE11_BEEF);

      applyStimulus(ChipEnable, WriteDisable, 32'h1000_FFFC, 4'hF, 32'h0, 1'b0);
      tick();
      checkOutput("oobRdRvalid", {31'b0, bus.rvalid}, 32'h1);
      checkOutput("oobRdErr",    {31'b0, bus.err},    32'h1);
      checkOutput("oobRdData",   bus.data_o,          32'h0);
      applyStimulus(ChipEnable, WriteEnable, BASE + 32'(4 * DEPTH), 4'hF, 32'hCAFE_F00D, 1'b0);
      tick();
      checkOutput("oobWrErr",    {31'b0, bus.err},    32'h1);
      checkOutput("oobWrRvalid", {31'b0, bus.rvalid}, 32'h0);
      applyStimulus(ChipDisable, WriteDisable, BASE, 4'h0, 32'h0, 1'b0);
      tick();
      checkOutput("errOnePulse", {31'b0, bus.err}, 32'h0);
      applyStimulus(ChipEnable, WriteDisable, BASE, 4'hF, 32'h0, 1'b0);
      tick();
      checkOutput("word0Intact", bus.data_o,       32'h0);
      checkOutput("word0Err",    {31'b0, bus.err}, 32'h0);

      applyStimulus(ChipDisable, WriteDisable, BASE + 32'h4, 4'hF, 32'h0, 1'b1);
      tick();
      applyStimulus(ChipEnable, WriteDisable, BASE + 32'h4, 4'hF, 32'h0, 1'b0);
      stallCycles = 0;
      while (!bus.ready && stallCycles < DEPTH + 16) begin
         bus.clear_req = (stallCycles == 5 || stallCycles == 6);
         tick();
         stallCycles++;
      end
      bus.clear_req = 1'b0;
      checkOutput("clearStall", stallCycles, DEPTH);
      tick();
      checkOutput("clearedRvalid", {31'b0, bus.rvalid}, 32'h1);
      checkOutput("clearedData",   bus.data_o,          32'h0);

      applyStimulus(ChipEnable, WriteEnable, BASE + 32'h8, 4'hF, 32'h0BAD_F00D, 1'b0);
      tick();
      applyStimulus(ChipEnable, WriteDisable, BASE + 32'h8, 4'hF, 32'h0, 1'b1);
      tick();
      checkOutput("accThenClrData",  bus.data_o,         32'h0BAD_F00D);
      checkOutput("accThenClrReady", {31'b0, bus.ready}, 32'h0);
      applyStimulus(ChipDisable, WriteDisable, BASE + 32'h8, 4'hF, 32'h0, 1'b0);
      for (int i = 0; i < 5; i++) tick();
      rst = 1'b0;
      #1;
      checkOutput("midRstReady",  {31'b0, bus.ready},  32'h0);
      checkOutput("midRstRvalid", {31'b0, bus.rvalid}, 32'h0);
      checkOutput("midRstData",   bus.data_o,          32'h0);
      rst = 1'b1;
      applyStimulus(ChipEnable, WriteDisable, BASE + 32'h8, 4'hF, 32'h0, 1'b0);
      countStall(stallCycles);
      checkOutput("restartStall", stallCycles, DEPTH);
      tick();
      checkOutput("restartRvalid", {31'b0, bus.rvalid}, 32'h1);
      checkOutput("restartData",   bus.data_o,          32'h0);

`ifdef DATA_RAM_SEG_TAP_EN
      applyStimulus(ChipEnable, WriteEnable, BASE, 4'hF, 32'h1234_5678, 1'b0);
      tick();
      checkOutput("tapWord", seg, 32'h1234_5678);
`endif

      applyStimulus(ChipDisable, WriteDisable, BASE, 4'h0, 32'h0, 1'b0);
      tick();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
